// File: rtl/remote_answer_arbiter_pkg.sv
// Shared types and helpers for the remote answer arbiter: FSM state encoding
// and the mapping between (player, choice) pairs and positions on the button bus.
package remote_pkg;

  localparam int MAX_PLAYERS = 8;
  localparam int MAX_CHOICES = 8;
  localparam int MAX_BTNS    = MAX_PLAYERS * MAX_CHOICES;
  localparam int IDX_W       = $clog2(MAX_BTNS);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    LOCKED
  } state_t;

  typedef struct packed {
    logic [7:0] player;
    logic [7:0] choice;
  } answer_t;

  // Bus position of 0-based player p, choice c; player 1 choice 1 sits at the MSB.
  function automatic int btn_index(input int p, input int c,
                                   input int num_players, input int num_choices);
    return (num_players - 1 - p) * num_choices + (num_choices - 1 - c);
  endfunction

  function automatic answer_t onehot_decode(input logic [MAX_BTNS-1:0] vec,
                                            input int num_players,
                                            input int num_choices);
    answer_t ans;
    ans = '0;
    for (int p = 0; p < MAX_PLAYERS; p++) begin
      for (int c = 0; c < MAX_CHOICES; c++) begin
        if (p < num_players && c < num_choices) begin
          if (vec[IDX_W'(btn_index(p, c, num_players, num_choices))]) begin
            ans.player = 8'(p + 1);
            ans.choice = 8'(c + 1);
          end
        end
      end
    end
    return ans;
  endfunction

endpackage

// File: rtl/remote_answer_arbiter_debounce.sv
// One remote button: two-flop synchroniser followed by a stability-count debouncer.
// The output is active-high (1 = button held).
module answer_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic active
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             stable_n;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= btn_n;
      sync_q2 <= sync_q1;
    end
  end

  // The accepted level flips on the cycle the mismatch count would reach DEBOUNCE_CYCLES.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_n <= 1'b1;
      cnt      <= '0;
    end else if (sync_q2 != stable_n) begin
      if (cnt == CNT_LAST) begin
        stable_n <= sync_q2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  assign active = ~stable_n;

endmodule

// File: rtl/remote_answer_arbiter.sv
// Debounces every remote button, grants the first clean single press of an armed
// round and holds the winning player/choice until the game controller clears it.
module remote_answer_arbiter
  import remote_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int NUM_CHOICES     = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PLAYERS*NUM_CHOICES-1:0]   btn_n,
  input  logic                                 arm,
  input  logic                                 clear,
  output logic                                 ans_valid,
  output logic [$clog2(NUM_PLAYERS+1)-1:0]     ans_player,
  output logic [$clog2(NUM_CHOICES+1)-1:0]     ans_choice,
  output logic                                 armed,
  output logic                                 collision,
  output logic                                 timeout
);

  localparam int NUM_BTNS = NUM_PLAYERS * NUM_CHOICES;
  localparam int PW       = $clog2(NUM_PLAYERS + 1);
  localparam int CW       = $clog2(NUM_CHOICES + 1);
  localparam int TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [NUM_BTNS-1:0] act;
  logic [NUM_BTNS-1:0] prev_act;
  state_t              state_q;
  state_t              state_d;
  logic [TW-1:0]       timer_q;
  logic [TW-1:0]       timer_d;
  logic                press_event;
  logic                act_onehot;
  answer_t             decoded;
  logic                capture;
  logic                collide;
  logic                expire;
  logic                ans_valid_d;
  logic [PW-1:0]       ans_player_d;
  logic [CW-1:0]       ans_choice_d;
  logic                armed_d;
  logic                collision_d;
  logic                timeout_d;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    answer_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .btn_n (btn_n[i]),
      .active(act[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_act <= '0;
    end else begin
      prev_act <= act;
    end
  end

  // A press only counts when the buttons were fully released the cycle before.
  assign press_event = (prev_act == '0) && (act != '0);
  assign act_onehot  = (act != '0) && ((act & (act - NUM_BTNS'(1))) == '0);
  assign decoded     = onehot_decode(MAX_BTNS'(act), NUM_PLAYERS, NUM_CHOICES);

  // A one-hot vector always decodes to a non-zero pair; the extra test rejects anything that does not.
  assign capture = (state_q == ARMED) && press_event && act_onehot &&
                   (decoded.player != '0) && (decoded.choice != '0);
  assign collide = (state_q == ARMED) && press_event && !act_onehot;
  assign expire  = TIMEOUT_EN && (state_q == ARMED) && (timer_q == TIMER_LAST) && !capture;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      ans_valid  <= 1'b0;
      ans_player <= '0;
      ans_choice <= '0;
      armed      <= 1'b0;
      collision  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ans_valid  <= ans_valid_d;
      ans_player <= ans_player_d;
      ans_choice <= ans_choice_d;
      armed      <= armed_d;
      collision  <= collision_d;
      timeout    <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (arm && (act == '0)) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (capture) begin
          state_d = LOCKED;
        end else if (expire) begin
          state_d = IDLE;
        end
      end
      LOCKED: begin
        state_d = LOCKED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (clear) begin
      state_d = IDLE;
    end
  end

  // clear wins over everything else on the same edge, including a capture.
  always_comb begin
    ans_valid_d  = ans_valid;
    ans_player_d = ans_player;
    ans_choice_d = ans_choice;
    armed_d      = (state_d == ARMED);
    collision_d  = 1'b0;
    timeout_d    = 1'b0;
    timer_d      = '0;
    if (clear) begin
      ans_valid_d  = 1'b0;
      ans_player_d = '0;
      ans_choice_d = '0;
    end else begin
      if (capture) begin
        ans_valid_d  = 1'b1;
        ans_player_d = PW'(decoded.player);
        ans_choice_d = CW'(decoded.choice);
      end
      collision_d = collide;
      timeout_d   = expire;
      if ((state_q == ARMED) && (state_d == ARMED)) begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

endmodule

// File: doc/remote_answer_arbiter.md
# remote_answer_arbiter

Parametrised successor to the two-player, four-choice remote decoder. Synchronises and debounces NUM_PLAYERS×NUM_CHOICES active-low remote buttons. Arbitrates the first clean single press in an armed round, then latches the winning player and choice until the game controller clears it. Sits between the remote receiver pins and the game/score controller that drives the seven-segment displays.

## Interface
Parameters:
- NUM_PLAYERS, 2, number of remotes (≥1)
- NUM_CHOICES, 4, answer buttons per remote (≥2)
- DEBOUNCE_CYCLES, 4, consecutive stable cycles before a button change is accepted (≥1)
- TIMEOUT_CYCLES, 0, ARMED-state time limit in cycles; 0 disables

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_n  in  NUM_PLAYERS*NUM_CHOICES  raw buttons, active-low; player p, choice c (both 0-based) at bit (NUM_PLAYERS-1-p)*NUM_CHOICES + (NUM_CHOICES-1-c), so MSB = player 1 choice 1
- arm  in  1  start a round (level sampled each cycle)
- clear  in  1  end round, release latched answer
- ans_valid  out  1  high while an answer is latched
- ans_player  out  $clog2(NUM_PLAYERS+1)  1-based winning player, 0 when not valid
- ans_choice  out  $clog2(NUM_CHOICES+1)  1-based winning choice, 0 when not valid
- armed  out  1  high in ARMED
- collision  out  1  one-cycle pulse: more than one button became active together in ARMED
- timeout  out  1  one-cycle pulse: ARMED expired

## Operation
- Per bit: 2-flop synchroniser (reset value 1 = released). Then a debouncer: a counter increments while the synchronised bit ≠ the debounced bit and resets to 0 when they match. The debounced bit flips on the edge where the counter would reach DEBOUNCE_CYCLES. Debounced active vector act = ~debounced; reset to all-zero.
- FSM states: IDLE, ARMED, LOCKED.
  - IDLE: outputs 0. Arm → ARMED, but only if act == 0; otherwise stay IDLE until released and arm still high.
  - ARMED: a press event is when prev_act == 0 and act ≠ 0. If act is one-hot, latch player/choice → LOCKED. If more than one bit is set, pulse collision and stay ARMED; a new event needs act to return to 0. If TIMEOUT_CYCLES > 0 and the timer hits TIMEOUT_CYCLES with no capture, pulse timeout → IDLE.
  - LOCKED: hold ans_*; ignore all buttons and arm.
- clear in any state → IDLE and zeros ans_*, same edge. clear beats arm and beats a capture on the same cycle.
- Changes of act while not ARMED never produce events. prev_act is still tracked every cycle.
- Reset: state IDLE, every output 0, counters 0, sync flops 1.

## Timing
- Button held low from sampling edge 1: debounced at edge DEBOUNCE_CYCLES+2; ans_valid, ans_player, ans_choice registered high after edge DEBOUNCE_CYCLES+3. Latency is DEBOUNCE_CYCLES+3 cycles.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles is rejected.
- armed rises 1 cycle after arm is sampled in IDLE with act == 0.
- Timeout counter starts at 0 on ARMED entry; timeout pulses exactly TIMEOUT_CYCLES cycles after entry.
- All outputs registered; no combinational input→output path.

## Structure
- Package remote_pkg: state enum {IDLE, ARMED, LOCKED}; functions btn_index(p,c) and onehot_decode(vec) → 1-based player/choice.
- Sub-module answer_debounce (parameter DEBOUNCE_CYCLES, 1-bit sync+debounce), instantiated NUM_PLAYERS*NUM_CHOICES times by generate.

## Test plan
- Defaults; arm; btn_n = 8'b11011111 held 10 cycles → ans_valid after 7 cycles, ans_player=1, ans_choice=3; held through further presses until clear.
- btn_n = 8'b11111110 low for 3 cycles only → no capture; then held → ans_player=2, ans_choice=4.
- btn_n = 8'b01111110 together → collision pulse, stays ARMED; release, then 8'b11110111 → player 2, choice 1.
- NUM_PLAYERS=4, NUM_CHOICES=3: player 4 choice 2 → ans_player=4, ans_choice=2; button held during arm → armed stays 0 until release.
- TIMEOUT_CYCLES=20, no press → timeout pulse 20 cycles after armed rises, armed=0.
- clear and arm both high during LOCKED → IDLE, outputs 0; rst mid-debounce → all outputs 0, later press needs full latency again.
